// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings and default sizes for the multi-channel PWM
package pwm_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_CHANNELS = 4;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared PWM counter, period boundary detection and period/mode transfer
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_center,
  output logic [WIDTH-1:0] count,
  output logic             boundary,
  output logic             period_tick,
  output logic             update_pending
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
  pwm_dir_e         dir_q, dir_d;
  pwm_mode_e        mode_q, mode_d;
  pwm_mode_e        shadow_mode_q, shadow_mode_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q         <= '0;
      period_q        <= '0;
      shadow_period_q <= '0;
      dir_q           <= DIR_UP;
      mode_q          <= PWM_EDGE;
      shadow_mode_q   <= PWM_EDGE;
      pending_q       <= 1'b0;
      tick_q          <= 1'b0;
    end else begin
      count_q         <= count_d;
      period_q        <= period_d;
      shadow_period_q <= shadow_period_d;
      dir_q           <= dir_d;
      mode_q          <= mode_d;
      shadow_mode_q   <= shadow_mode_d;
      pending_q       <= pending_d;
      tick_q          <= tick_d;
    end
  end

  // A disabled timebase sits at a boundary every cycle so pending config lands immediately.
  always_comb begin
    boundary = 1'b1;
    if (enable) begin
      if (mode_q == PWM_EDGE) begin
        boundary = (count_q == period_q);
      end else begin
        boundary = (period_q == '0) ||
                   ((count_q == WIDTH'(1)) && ((dir_q == DIR_DOWN) || (period_q == WIDTH'(1))));
      end
    end
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    if (boundary) begin
      count_d = '0;
      dir_d   = DIR_UP;
    end else if (mode_q == PWM_EDGE) begin
      count_d = count_q + WIDTH'(1);
    end else if (dir_q == DIR_UP) begin
      if (count_q == period_q) begin
        count_d = count_q - WIDTH'(1);
        dir_d   = DIR_DOWN;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // A write landing on the boundary goes straight through to the active set.
  always_comb begin
    shadow_period_d = cfg_we ? cfg_period : shadow_period_q;
    shadow_mode_d   = cfg_we ? pwm_mode_e'(cfg_center) : shadow_mode_q;
    period_d        = period_q;
    mode_d          = mode_q;
    if (boundary && (pending_q || cfg_we)) begin
      period_d = shadow_period_d;
      mode_d   = shadow_mode_d;
    end
    pending_d = boundary ? 1'b0 : (pending_q || cfg_we);
    tick_d    = boundary;
  end

  always_comb begin
    count          = count_q;
    period_tick    = tick_q & enable;
    update_pending = pending_q;
  end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with double-buffered duty and a shared timebase
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_we,
  input  logic [WIDTH-1:0]          cfg_period,
  input  logic [CHANNELS*WIDTH-1:0] cfg_duty,
  input  logic                      cfg_center,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick,
  output logic                      update_pending
);

  logic [WIDTH-1:0]          count;
  logic                      boundary;
  logic [CHANNELS*WIDTH-1:0] duty_shadow_q, duty_shadow_d;
  logic [CHANNELS*WIDTH-1:0] duty_active_q, duty_active_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;

  pwm_timebase #(
    .WIDTH (WIDTH)
  ) u_timebase (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cfg_we         (cfg_we),
    .cfg_period     (cfg_period),
    .cfg_center     (cfg_center),
    .count          (count),
    .boundary       (boundary),
    .period_tick    (period_tick),
    .update_pending (update_pending)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_shadow_q <= '0;
      duty_active_q <= '0;
      pwm_q         <= '0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
    end
  end

  // Duty follows the same transfer rule the timebase applies to period and mode.
  always_comb begin
    duty_shadow_d = cfg_we ? cfg_duty : duty_shadow_q;
    duty_active_d = duty_active_q;
    if (boundary && (update_pending || cfg_we)) begin
      duty_active_d = duty_shadow_d;
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = enable && (count < duty_active_q[i*WIDTH +: WIDTH]);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - bench for pwm_multi against a phase-based reference model
module tb_pwm_multi;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           cfg_we = 1'b0;
  logic           cfg_center = 1'b0;
  logic [W-1:0]   cfg_period = '0;
  logic [N*W-1:0] cfg_duty = '0;
  logic [N-1:0]   pwm_out;
  logic           period_tick;
  logic           update_pending;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cfg_we         (cfg_we),
    .cfg_period     (cfg_period),
    .cfg_duty       (cfg_duty),
    .cfg_center     (cfg_center),
    .pwm_out        (pwm_out),
    .period_tick    (period_tick),
    .update_pending (update_pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: phase t is the cycle index within the current period.
  int         t;
  int         a_p, s_p;
  bit         a_c, s_c;
  int         a_d[N];
  int         s_d[N];
  bit         pend, fresh;
  bit [N-1:0] m_pwm;

  int hi[N];
  int ticks;
  bit last_tick, last_pend;
  logic [N-1:0] last_pwm;

  function automatic int plen(int p, bit c);
    if (c) return (p == 0) ? 1 : 2 * p;
    return p + 1;
  endfunction

  function automatic int cnt_of(int tt, int p, bit c);
    if (!c || tt <= p) return tt;
    return 2 * p - tt;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(bit rst);
    int  cnt;
    bit  bnd;
    if (rst) begin
      t = 0; a_p = 0; s_p = 0; a_c = 0; s_c = 0; pend = 0; fresh = 1; m_pwm = '0;
      for (int i = 0; i < N; i++) begin a_d[i] = 0; s_d[i] = 0; end
      return;
    end
    cnt = cnt_of(t, a_p, a_c);
    for (int i = 0; i < N; i++) m_pwm[i] = enable && (cnt < a_d[i]);
    bnd = !enable || (t == plen(a_p, a_c) - 1);
    if (cfg_we) begin
      s_p = int'(cfg_period);
      s_c = cfg_center;
      for (int i = 0; i < N; i++) s_d[i] = int'(cfg_duty[i*W +: W]);
    end
    if (bnd) begin
      if (cfg_we || pend) begin
        a_p = s_p; a_c = s_c;
        for (int i = 0; i < N; i++) a_d[i] = s_d[i];
      end
      pend = 0;
      t = 0;
    end else begin
      t++;
      if (cfg_we) pend = 1;
    end
    fresh = 0;
  endtask

  task automatic set_cfg(int p, bit c, logic [N*W-1:0] d);
    cfg_period = W'(p);
    cfg_center = c;
    cfg_duty   = d;
  endtask

  task automatic cyc(bit en, bit we);
    enable = en;
    cfg_we = we;
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("update_pending", 32'(update_pending), 32'(pend));
    chk("period_tick", 32'(period_tick), 32'(en && t == 0 && !fresh));
    last_tick = period_tick;
    last_pend = update_pending;
    last_pwm  = pwm_out;
    ticks += int'(period_tick);
    for (int i = 0; i < N; i++) hi[i] += int'(pwm_out[i]);
    @(posedge clk);
    model_step(1'b0);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    cfg_we = 1'b0;
    @(posedge clk);
    model_step(1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    ticks = 0;
    for (int i = 0; i < N; i++) hi[i] = 0;
  endtask

  initial begin
    int k;
    logic [N*W-1:0] d;
    @(negedge clk);
    do_reset();

    // Edge mode, P=9, D=[0,3,9,10]
    set_cfg(9, 1'b0, {8'd10, 8'd9, 8'd3, 8'd0});
    cyc(1, 1);
    repeat (12) cyc(1, 0);
    clear_counts();
    repeat (10) cyc(1, 0);
    chk("edge_ch0_high", hi[0], 0);
    chk("edge_ch1_high", hi[1], 3);
    chk("edge_ch2_high", hi[2], 9);
    chk("edge_ch3_high", hi[3], 10);
    chk("edge_ticks", ticks, 1);

    // Center mode, P=4, D=[2,0,4,5]
    set_cfg(4, 1'b1, {8'd5, 8'd4, 8'd0, 8'd2});
    cyc(1, 1);
    repeat (22) cyc(1, 0);
    clear_counts();
    repeat (8) cyc(1, 0);
    chk("center_ch0_high", hi[0], 3);
    chk("center_ch1_high", hi[1], 0);
    chk("center_ch2_high", hi[2], 7);
    chk("center_ch3_high", hi[3], 8);
    chk("center_ticks", ticks, 1);

    // Mid-period write: P 9 -> 4 at count 5
    set_cfg(9, 1'b0, {8'd10, 8'd9, 8'd3, 8'd0});
    cyc(1, 1);
    k = 0;
    while (k < 40 && !(t == 5 && a_p == 9 && !a_c && !pend)) begin cyc(1, 0); k++; end
    chk("wait_count5", 32'(k < 40), 32'd1);
    set_cfg(4, 1'b0, {8'd4, 8'd3, 8'd1, 8'd0});
    cyc(1, 1);
    k = 0;
    do begin cyc(1, 0); k++; end while (!last_tick && k < 30);
    chk("midwrite_cycles_to_tick", k, 5);
    chk("midwrite_pending_at_tick", 32'(last_pend), 32'd0);
    k = 0;
    do begin cyc(1, 0); k++; end while (!last_tick && k < 30);
    chk("new_period_len", k, 5);

    // Write coincident with the boundary (count == P == 4)
    k = 0;
    while (k < 20 && t != 4) begin cyc(1, 0); k++; end
    set_cfg(6, 1'b0, {8'd7, 8'd6, 8'd2, 8'd1});
    cyc(1, 1);
    cyc(1, 0);
    chk("boundary_write_tick", 32'(last_tick), 32'd1);
    chk("boundary_write_no_pending", 32'(last_pend), 32'd0);
    k = 0;
    do begin cyc(1, 0); k++; end while (!last_tick && k < 30);
    chk("boundary_write_period", k, 7);

    // Disable mid-period with a pending write, then re-enable
    k = 0;
    while (k < 20 && t != 2) begin cyc(1, 0); k++; end
    set_cfg(3, 1'b0, {8'd0, 8'd1, 8'd2, 8'd4});
    cyc(1, 1);
    cyc(0, 0);
    cyc(0, 0);
    chk("disabled_pwm_low", 32'(last_pwm), 32'd0);
    chk("disabled_applied", 32'(last_pend), 32'd0);
    cyc(1, 0);
    chk("reenable_tick", 32'(last_tick), 32'd1);
    clear_counts();
    repeat (4) cyc(1, 0);
    chk("reenable_ch0_high", hi[0], 4);
    chk("reenable_ticks", ticks, 1);

    // Reset during a center-mode run with a pending write
    set_cfg(4, 1'b1, {8'd3, 8'd3, 8'd3, 8'd3});
    cyc(1, 1);
    k = 0;
    while (k < 30 && !(t == 2 && a_p == 4 && a_c && !pend)) begin cyc(1, 0); k++; end
    set_cfg(7, 1'b1, {8'd9, 8'd9, 8'd9, 8'd9});
    cyc(1, 1);
    cyc(1, 0);
    chk("pending_before_reset", 32'(last_pend), 32'd1);
    do_reset();
    cyc(1, 0);
    chk("post_reset_pwm", 32'(last_pwm), 32'd0);
    chk("post_reset_pending", 32'(last_pend), 32'd0);
    chk("post_reset_tick", 32'(last_tick), 32'd0);
    clear_counts();
    repeat (10) cyc(1, 0);
    chk("p0_high_total", hi[0] + hi[1] + hi[2] + hi[3], 0);
    chk("p0_ticks", ticks, 10);

    // Randomized traffic
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bit we;
        we = ($urandom_range(0, 9) == 0);
        if (we) begin
          for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom_range(0, 14));
          set_cfg(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), d);
        end
        cyc($urandom_range(0, 15) != 0, we);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator for the synthesizer audio output stage. One shared timebase (edge- or center-aligned) drives `CHANNELS` duty comparators. Period, duty and mode are double-buffered and take effect only at a period boundary, so updates are glitch-free. Sits between the voice/mixer register interface and the output pins or low-pass filter.

## Interface
Parameters:
- `WIDTH`, default 8: counter, period and duty width in bits.
- `CHANNELS`, default 4: number of independent PWM outputs.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run timebase; low forces outputs low and holds count at 0.
- `cfg_we`  in  1  single-cycle write strobe for the shadow configuration.
- `cfg_period`  in  WIDTH  period value P.
- `cfg_duty`  in  CHANNELS*WIDTH  duty D[i], packed, channel i at bits [i*WIDTH +: WIDTH].
- `cfg_center`  in  1  0 = edge-aligned, 1 = center-aligned.
- `pwm_out`  out  CHANNELS  registered PWM outputs.
- `period_tick`  out  1  one-cycle pulse marking the start of a new period.
- `update_pending`  out  1  shadow configuration written but not yet active.

## Operation
- Registers: shadow (P, D[], center), active (P, D[], center), count[WIDTH], dir (up/down), pending.
- `cfg_we`: shadow <= cfg inputs; pending <= 1. Writes are last-wins.
- Edge mode: count runs 0,1,…,P, then 0. Period is P+1 cycles. Boundary cycle is count==P.
- Center mode: count runs up 0…P, then down P-1…1, then 0. Period is 2P cycles. Boundary cycle is count==1 with dir down.
- Center mode with P<=1 behaves as follows: P=1 gives 0,1,0,1 with the boundary at count==1; P=0 gives a constant 0 with every cycle a boundary.
- Edge mode with P=0 gives a constant count of 0 with every cycle a boundary.
- At a boundary cycle with pending=1: active <= shadow and pending <= 0. The next cycle starts count=0, dir up, using the new config.
- `cfg_we` in the same cycle as a boundary: the written values go directly into active (write-through), and pending stays 0.
- `enable`=0:
  - count=0, dir=up, and every cycle is treated as a boundary, so pending config applies next clock.
  - `pwm_out`=0 and `period_tick`=0.
- Compare per channel: `pwm_out[i]` <= enable & (count < D[i]).
  - D=0 gives always low.
  - D>P in edge mode, or D>P in center mode, gives always high.
  - Center mode yields a symmetric pulse of width 2·D-1 cycles for 1<=D<=P.
- All arithmetic is unsigned WIDTH-bit. count never exceeds active P, so no wrap-around beyond the defined sequence.

## Timing
- Reset values: count=0, dir=up, shadow and active all zero, pending=0, `pwm_out`=0, `period_tick`=0, `update_pending`=0.
- `pwm_out` lags count by 1 cycle (registered compare).
- `period_tick` is registered. It is high in the cycle where count==0 at the start of each period, which is the first cycle the new active config is in effect. It is also high on the first count==0 after `enable` rises.
- `update_pending` is high from the cycle after `cfg_we` until the cycle after the applying boundary.
- Config latency: a write is visible at the next boundary, i.e. at most P+1 cycles (edge) or 2P cycles (center).
- `reset` mid-period clears everything immediately. Pending writes are discarded.

## Structure
- Shared package/header `pwm_pkg`: mode encodings (`PWM_EDGE`=0, `PWM_CENTER`=1), direction encodings, and default `WIDTH`/`CHANNELS`.
- Sub-module `pwm_timebase`:
  - Owns count, dir, boundary detection, and the shadow→active transfer of P and mode.
  - Outputs count, boundary and period_tick.
- Top level owns the shadow/active duty arrays and a generate loop of comparators.

## Test plan
- Edge mode, P=9, D=[0,3,9,10], enable=1 → period 10 cycles. ch0 is always 0, ch1 is high 3 of 10 cycles, ch2 is high 9 of 10, ch3 is always 1. `period_tick` pulses every 10 cycles.
- Center mode, P=4, D[0]=2 → count 0,1,2,3,4,3,2,1 repeating. ch0 is high 3 of 8 cycles, centered on count 0. Tick every 8 cycles.
- Mid-period `cfg_we`: P 9→4 at count=5 → `update_pending`=1. Old period completes at count 9, then the next period is 5 cycles. `update_pending` clears coincident with the tick.
- `cfg_we` coincident with the boundary cycle (count==P) → new config is active at the very next count=0, and `update_pending` never asserts.
- `enable` toggled low mid-period with a pending write → outputs 0 the next cycle and the config is applied. On re-enable, count starts at 0 and a tick is emitted.
- `reset` asserted during an active center-mode run with pending=1 → all outputs 0 and count=0 the next cycle. The pending write is lost, and after release P=0 gives constant-low outputs.
